aes_job_scheduler: RTL and testbench

- Queues AES job requests (key, SRAM base address, block count, mode) from the SPI front end in a small FIFO.
- Dispatches jobs one at a time to the AES datapath: key expansion → counter/SRAM-controller clear → run, then waits for the finish flag.
- Sits between spi_slave and the key expansion / pipe counter / SRAM controllers, replacing single-shot start handling so back-to-back jobs need no host polling.
- Skips key expansion when the next job reuses the key already expanded.

---
 rtl/aes_job_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_job_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
//   Queues AES job requests from the SPI front end and runs them one at a
//   time on the AES datapath: key expansion, counter/controller clear, run,
//   then wait for the datapath finish flag. Key expansion is skipped when the
//   next job uses the key that is already expanded.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid / req_ready  job request handshake
//   req_key/addr/loc/mode  job fields (key, SRAM start, block count, 1=encrypt)
//   abort                  cancel the running job and flush the queue
//   fin_in                 datapath finished
//   key/s_addr/loc/en_or_de  fields of the most recently dispatched job
//   key_en                 key expansion enable (KEY_CYCLES cycles)
//   core_clr               one-cycle clear to counters/controllers
//   con_en                 controller/timer run enable
//   job_done / job_err     completion pulse, job_err=1 on watchdog timeout
//   busy, fifo_count       activity flag and queue occupancy
module aes_job_scheduler #(
    parameter int DEPTH      = 4,
    parameter int KEY_CYCLES = 11,
    parameter int WATCHDOG   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [127:0]             req_key,
    input  logic [7:0]               req_addr,
    input  logic [7:0]               req_loc,
    input  logic                     req_mode,
    input  logic                     abort,
    input  logic                     fin_in,
    output logic [127:0]             key,
    output logic [7:0]               s_addr,
    output logic [7:0]               loc,
    output logic                     en_or_de,
    output logic                     key_en,
    output logic                     core_clr,
    output logic                     con_en,
    output logic                     job_done,
    output logic                     job_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int KW      = $clog2(KEY_CYCLES) + 1;
    localparam int WW      = $clog2(WATCHDOG) + 1;
    localparam int ENTRY_W = 128 + 8 + 8 + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [KW-1:0] KEY_LAST = KW'(KEY_CYCLES - 1);
    localparam logic [KW-1:0] KEY_ONE  = KW'(1);
    localparam logic [WW-1:0] WD_MAX   = WW'(WATCHDOG);
    localparam logic [WW-1:0] WD_ONE   = WW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KEY  = 3'd1,
        S_CLR  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 key_valid_q, key_valid_d;
    logic [KW-1:0]        key_cnt_q, key_cnt_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic                 err_d;
    logic                 pop_s, push_s;
    logic [ENTRY_W-1:0]   head_s;
    logic [127:0]         head_key_s;
    logic [127:0]         key_q;
    logic [7:0]           s_addr_q, loc_q;
    logic                 en_or_de_q;
    logic                 key_en_q, core_clr_q, con_en_q, job_done_q, job_err_q;

    assign head_s     = mem_q[rd_ptr_q];
    assign head_key_s = head_s[127:0];

    // A pop frees a slot in the same cycle, so a full queue still accepts then.
    assign req_ready  = (count_q < CNT_FULL) || pop_s;
    assign push_s     = req_valid && !abort && ((count_q < CNT_FULL) || pop_s);

    // Next-state logic for the dispatch sequence and its counters.
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        key_cnt_d   = key_cnt_q;
        wd_d        = wd_q;
        err_d       = 1'b0;
        pop_s       = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        pop_s = 1'b1;
                        if (key_valid_q && (head_key_s == key_q)) begin
                            state_d = S_CLR;
                        end else begin
                            // The expanded key is being replaced; it is not
                            // valid again until this expansion completes.
                            state_d     = S_KEY;
                            key_cnt_d   = '0;
                            key_valid_d = 1'b0;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_KEY: begin
                    if (key_cnt_q == KEY_LAST) begin
                        state_d     = S_CLR;
                        key_valid_d = 1'b1;
                    end else begin
                        key_cnt_d = key_cnt_q + KEY_ONE;
                    end
                end
                S_CLR: begin
                    state_d = S_RUN;
                    wd_d    = WD_ONE;
                end
                S_RUN: begin
                    // A finish in the timeout cycle still counts as success.
                    if (fin_in) begin
                        state_d = S_DONE;
                    end else if (wd_q == WD_MAX) begin
                        state_d     = S_DONE;
                        err_d       = 1'b1;
                        key_valid_d = 1'b0;
                    end else begin
                        wd_d = wd_q + WD_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Job queue storage; contents are only read while occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {req_mode, req_loc, req_addr, req_key};
        end
    end

    // State, queue pointers, dispatched job fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            key_valid_q <= 1'b0;
            key_cnt_q   <= '0;
            wd_q        <= '0;
            key_q       <= '0;
            s_addr_q    <= '0;
            loc_q       <= '0;
            en_or_de_q  <= 1'b0;
            key_en_q    <= 1'b0;
            core_clr_q  <= 1'b0;
            con_en_q    <= 1'b0;
            job_done_q  <= 1'b0;
            job_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_cnt_q   <= key_cnt_d;
            wd_q        <= wd_d;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
            if (pop_s) begin
                key_q      <= head_s[127:0];
                s_addr_q   <= head_s[135:128];
                loc_q      <= head_s[143:136];
                en_or_de_q <= head_s[144];
            end
            key_en_q   <= (state_d == S_KEY);
            core_clr_q <= (state_d == S_CLR);
            con_en_q   <= (state_d == S_RUN);
            job_done_q <= (state_d == S_DONE);
            job_err_q  <= err_d;
        end
    end

    assign key        = key_q;
    assign s_addr     = s_addr_q;
    assign loc        = loc_q;
    assign en_or_de   = en_or_de_q;
    assign key_en     = key_en_q;
    assign core_clr   = core_clr_q;
    assign con_en     = con_en_q;
    assign job_done   = job_done_q;
    assign job_err    = job_err_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Testbench for aes_job_scheduler: a directed table of cycle segments with
// hand-derived expected outputs, then random traffic, both compared every
// cycle against a timestamp-based reference model.
module tb_aes_job_scheduler;

    localparam int DEPTH = 4;
    localparam int KC    = 11;
    localparam int WD    = 16;

    localparam int PH_IDLE = 0;
    localparam int PH_KEY  = 1;
    localparam int PH_CLR  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_DONE = 4;

    // expected {key_en, core_clr, con_en, job_done, job_err, busy}
    localparam bit [5:0] P_IDLE  = 6'b000000;
    localparam bit [5:0] P_IDLEB = 6'b000001;
    localparam bit [5:0] P_KEY   = 6'b100001;
    localparam bit [5:0] P_CLR   = 6'b010001;
    localparam bit [5:0] P_RUN   = 6'b001001;
    localparam bit [5:0] P_DONE  = 6'b000101;
    localparam bit [5:0] P_DERR  = 6'b000111;

    logic         clk = 1'b0;
    logic         rst, req_valid, req_ready, req_mode, abort, fin_in;
    logic [127:0] req_key, key;
    logic [7:0]   req_addr, req_loc, s_addr, loc;
    logic         en_or_de, key_en, core_clr, con_en, job_done, job_err, busy;
    logic [2:0]   fifo_count;

    aes_job_scheduler #(.DEPTH(DEPTH), .KEY_CYCLES(KC), .WATCHDOG(WD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_addr(req_addr), .req_loc(req_loc),
        .req_mode(req_mode), .abort(abort), .fin_in(fin_in), .key(key),
        .s_addr(s_addr), .loc(loc), .en_or_de(en_or_de), .key_en(key_en),
        .core_clr(core_clr), .con_en(con_en), .job_done(job_done),
        .job_err(job_err), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       reps;
        bit       rst, v;
        int       ks;
        bit [7:0] addr, loc;
        bit       md, ab, fin, chk;
        bit [5:0] p;
        int       cnt;
        bit       rdy, eod;
    } vec_t;

    typedef struct {
        logic [127:0] key;
        logic [7:0]   addr, loc;
        logic         mode;
    } job_t;

    vec_t         tab[$];
    logic [127:0] keys [3];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;

    // Reference model: queued jobs plus timestamps of the dispatched job.
    job_t mq[$];
    job_t m_cur;
    bit   m_active = 1'b0;
    bit   m_kv     = 1'b0;
    bit   m_err    = 1'b0;
    bit   m_ok     = 1'b0;
    int   m_kend   = 0;
    int   m_done   = -1;

    function automatic void add(int reps, bit r, bit v, int ks, bit [7:0] ad,
                                bit [7:0] lc, bit md, bit ab, bit fin, bit ck,
                                bit [5:0] p, int cnt, bit rdy, bit eod);
        vec_t t;
        t.reps = reps; t.rst = r; t.v = v; t.ks = ks; t.addr = ad; t.loc = lc;
        t.md = md; t.ab = ab; t.fin = fin; t.chk = ck; t.p = p; t.cnt = cnt;
        t.rdy = rdy; t.eod = eod;
        tab.push_back(t);
    endfunction

    // Phase of the dispatched job during cycle c, from its timestamps.
    function automatic int phase(int c);
        if (!m_active)                  return PH_IDLE;
        if (c <= m_kend)                return PH_KEY;
        if (c == m_kend + 1)            return PH_CLR;
        if (m_done >= 0 && c == m_done) return PH_DONE;
        return PH_RUN;
    endfunction

    // Advance the model over the clock edge that ends cycle cyc.
    function automatic void model_step();
        int   ph;
        bit   pop, push, reuse;
        job_t j, nj;
        ph = phase(cyc);
        nj.key = req_key; nj.addr = req_addr; nj.loc = req_loc; nj.mode = req_mode;
        if (rst) begin
            mq.delete();
            m_active = 1'b0; m_kv = 1'b0; m_err = 1'b0; m_done = -1;
            m_cur.key = '0; m_cur.addr = '0; m_cur.loc = '0; m_cur.mode = 1'b0;
            m_ok = 1'b1;
        end else if (abort) begin
            mq.delete();
            m_active = 1'b0; m_kv = 1'b0;
        end else begin
            pop  = (ph == PH_IDLE) && (mq.size() > 0);
            push = req_valid && ((mq.size() < DEPTH) || pop);
            if (ph == PH_IDLE && pop) begin
                j = mq.pop_front();
                reuse = m_kv && (j.key == m_cur.key);
                m_cur = j;
                m_kend = reuse ? cyc : cyc + KC;
                if (!reuse) m_kv = 1'b0;
                m_active = 1'b1;
                m_done = -1;
            end else if (ph == PH_KEY && cyc == m_kend) begin
                m_kv = 1'b1;
            end else if (ph == PH_RUN && m_done < 0) begin
                if (fin_in) begin
                    m_done = cyc + 1; m_err = 1'b0;
                end else if (cyc == m_kend + 1 + WD) begin
                    m_done = cyc + 1; m_err = 1'b1; m_kv = 1'b0;
                end
            end else if (ph == PH_DONE) begin
                m_active = 1'b0;
            end
            if (push) mq.push_back(nj);
        end
        cyc++;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        int ph;
        bit rdy_e;
        ph = phase(cyc);
        rdy_e = (mq.size() < DEPTH) || (ph == PH_IDLE && mq.size() > 0 && !abort);
        chk("m_key_en",   128'(key_en),     128'(ph == PH_KEY));
        chk("m_core_clr", 128'(core_clr),   128'(ph == PH_CLR));
        chk("m_con_en",   128'(con_en),     128'(ph == PH_RUN));
        chk("m_job_done", 128'(job_done),   128'(ph == PH_DONE));
        chk("m_job_err",  128'(job_err),    128'(ph == PH_DONE && m_err));
        chk("m_busy",     128'(busy),       128'(ph != PH_IDLE || mq.size() > 0));
        chk("m_count",    128'(fifo_count), 128'(mq.size()));
        chk("m_ready",    128'(req_ready),  128'(rdy_e));
        chk("m_key",      key,              m_cur.key);
        chk("m_s_addr",   128'(s_addr),     128'(m_cur.addr));
        chk("m_loc",      128'(loc),        128'(m_cur.loc));
        chk("m_en_or_de", 128'(en_or_de),   128'(m_cur.mode));
    endtask

    task automatic table_check(input vec_t t);
        chk("t_key_en",   128'(key_en),     128'(t.p[5]));
        chk("t_core_clr", 128'(core_clr),   128'(t.p[4]));
        chk("t_con_en",   128'(con_en),     128'(t.p[3]));
        chk("t_job_done", 128'(job_done),   128'(t.p[2]));
        chk("t_job_err",  128'(job_err),    128'(t.p[1]));
        chk("t_busy",     128'(busy),       128'(t.p[0]));
        chk("t_count",    128'(fifo_count), 128'(t.cnt));
        chk("t_ready",    128'(req_ready),  128'(t.rdy));
        chk("t_en_or_de", 128'(en_or_de),   128'(t.eod));
    endtask

    initial begin
        int cnt_i;
        keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
        keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[2] = 128'hfedcba98765432100123456789abcdef;
        rst = 1'b1; req_valid = 1'b0; req_key = '0; req_addr = '0; req_loc = '0;
        req_mode = 1'b0; abort = 1'b0; fin_in = 1'b0;

        // reset
        add(1,1,0,0,8'h00,8'h00,0,0,0,0,P_IDLE,0,1,0);
        add(1,1,0,0,8'h00,8'h00,0,0,0,1,P_IDLE,0,1,0);
        // single encrypt job, fresh key
        add(1,0,1,0,8'h10,8'h28,1,0,0,1,P_IDLE,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLEB,1,1,0);
        add(KC,0,0,0,8'h00,8'h00,0,0,0,1,P_KEY,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,0,1,1);
        add(7,0,0,0,8'h00,8'h00,0,0,0,1,P_RUN,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLE,0,1,1);
        // two jobs, same key, second decrypt: no KEY phase
        add(1,0,1,0,8'h20,8'h30,1,0,0,1,P_IDLE,0,1,1);
        add(1,0,1,0,8'h40,8'h50,0,0,0,1,P_IDLEB,1,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,1,1,1);
        add(3,0,0,0,8'h00,8'h00,0,0,0,1,P_RUN,1,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,1,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,1,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLEB,1,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,0,1,0);
        add(2,0,0,0,8'h00,8'h00,0,0,0,1,P_RUN,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLE,0,1,0);
        // fill the queue while busy; 5th request dropped; push+pop at full
        add(1,0,1,1,8'h60,8'h01,1,0,0,1,P_IDLE,0,1,0);
        add(1,0,1,1,8'h61,8'h02,0,0,0,1,P_IDLEB,1,1,0);
        add(1,0,1,1,8'h62,8'h03,1,0,0,1,P_KEY,1,1,1);
        add(1,0,1,1,8'h63,8'h04,0,0,0,1,P_KEY,2,1,1);
        add(1,0,1,1,8'h64,8'h05,1,0,0,1,P_KEY,3,1,1);
        add(1,0,1,1,8'h65,8'h06,0,0,0,1,P_KEY,4,0,1);
        add(KC-4,0,0,0,8'h00,8'h00,0,0,0,1,P_KEY,4,0,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,4,0,1);
        add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,4,0,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,4,0,1);
        add(1,0,1,1,8'h66,8'h07,0,0,0,1,P_IDLEB,4,1,1);
        for (int i = 0; i < 5; i++) begin
            cnt_i = 4 - i;
            add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,cnt_i,cnt_i < 4,i % 2);
            add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,cnt_i,cnt_i < 4,i % 2);
            add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,cnt_i,cnt_i < 4,i % 2);
            add(1,0,0,0,8'h00,8'h00,0,0,0,1,(cnt_i > 0) ? P_IDLEB : P_IDLE,cnt_i,1,i % 2);
        end
        // watchdog timeout, then the same key must be expanded again
        add(1,0,1,1,8'h70,8'h08,1,0,0,1,P_IDLE,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLEB,1,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,0,1,1);
        add(WD,0,0,0,8'h00,8'h00,0,0,0,1,P_RUN,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DERR,0,1,1);
        add(1,0,1,1,8'h71,8'h09,0,0,0,1,P_IDLE,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLEB,1,1,1);
        add(KC,0,0,0,8'h00,8'h00,0,0,0,1,P_KEY,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,0,1,0);
        add(2,0,0,0,8'h00,8'h00,0,0,0,1,P_RUN,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLE,0,1,0);
        // abort mid-KEY with two jobs queued, push on abort cycle dropped
        add(1,0,1,2,8'h80,8'h0a,1,0,0,1,P_IDLE,0,1,0);
        add(1,0,1,2,8'h81,8'h0b,0,0,0,1,P_IDLEB,1,1,0);
        add(1,0,1,2,8'h82,8'h0c,1,0,0,1,P_KEY,1,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_KEY,2,1,1);
        add(1,0,1,2,8'h83,8'h0d,0,1,0,1,P_KEY,2,1,1);
        add(2,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLE,0,1,1);
        add(1,0,1,2,8'h84,8'h0e,0,0,0,1,P_IDLE,0,1,1);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLEB,1,1,1);
        add(KC,0,0,0,8'h00,8'h00,0,0,0,1,P_KEY,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,1,1,P_RUN,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_DONE,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLE,0,1,0);
        // reset while running; later fin_in ignored
        add(1,0,1,2,8'h90,8'h0f,1,0,0,1,P_IDLE,0,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_IDLEB,1,1,0);
        add(1,0,0,0,8'h00,8'h00,0,0,0,1,P_CLR,0,1,1);
        add(1,0,1,0,8'h91,8'h10,0,0,0,1,P_RUN,0,1,1);
        add(2,0,0,0,8'h00,8'h00,0,0,0,1,P_RUN,1,1,1);
        add(1,1,0,0,8'h00,8'h00,0,0,0,1,P_RUN,1,1,1);
        add(3,0,0,0,8'h00,8'h00,0,0,1,1,P_IDLE,0,1,0);

        foreach (tab[k]) begin
            for (int r = 0; r < tab[k].reps; r++) begin
                @(negedge clk);
                rst       = tab[k].rst;
                req_valid = tab[k].v;
                req_key   = keys[tab[k].ks];
                req_addr  = tab[k].addr;
                req_loc   = tab[k].loc;
                req_mode  = tab[k].md;
                abort     = tab[k].ab;
                fin_in    = tab[k].fin;
                #1;
                if (tab[k].chk) table_check(tab[k]);
                if (m_ok) model_check();
                @(posedge clk);
                model_step();
            end
        end

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 499) == 0);
            req_valid = ($urandom_range(0, 1) == 1);
            req_key   = keys[$urandom_range(0, 2)];
            req_addr  = 8'($urandom_range(0, 255));
            req_loc   = 8'($urandom_range(0, 255));
            req_mode  = ($urandom_range(0, 1) == 1);
            abort     = ($urandom_range(0, 99) == 0);
            fin_in    = ($urandom_range(0, 9) == 0);
            #1;
            model_check();
            @(posedge clk);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
